// File: rtl/alu_sequencer.sv
// Operand-side initiator for the 16-bit ALU: takes a command, drives registered
// operands, waits SETTLE cycles per iteration and returns the final result.
module alu_sequencer #(
   parameter int WIDTH  = 16,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_da,
   input  logic [WIDTH-1:0] cmd_db,
   input  logic [2:0]       cmd_ctl,
   input  logic [3:0]       cmd_shift,
   input  logic             cmd_chain,
   input  logic [3:0]       cmd_repeat,
   output logic [WIDTH-1:0] ALU_DA,
   output logic [WIDTH-1:0] ALU_DB,
   output logic [2:0]       ALU_CTL,
   output logic [3:0]       ALU_SHIFT,
   input  logic [WIDTH-1:0] ALU_DC,
   input  logic             ALU_OverFlow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_overflow,
   output logic             busy
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t           state;
   logic [WIDTH-1:0] last_result;
   logic [3:0]       iter;
   logic [SW-1:0]    settle;
   logic             ovf_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_overflow <= 1'b0;
         busy         <= 1'b0;
         ALU_DA       <= '0;
         ALU_DB       <= '0;
         ALU_CTL      <= '0;
         ALU_SHIFT    <= '0;
         last_result  <= '0;
         iter         <= '0;
         settle       <= '0;
         ovf_acc      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  ALU_DA    <= cmd_chain ? last_result : cmd_da;
                  ALU_DB    <= cmd_db;
                  ALU_CTL   <= cmd_ctl;
                  ALU_SHIFT <= cmd_shift;
                  iter      <= cmd_repeat;
                  settle    <= SETTLE_LD;
                  ovf_acc   <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               if (settle != '0) begin
                  settle <= settle - 1'b1;
               end else if (iter == '0) begin
                  rsp_data     <= ALU_DC;
                  rsp_overflow <= ovf_acc | ALU_OverFlow;
                  rsp_valid    <= 1'b1;
                  state        <= RESP;
               end else begin
                  // feed the result back as operand A for the next pass
                  ALU_DA  <= ALU_DC;
                  ovf_acc <= ovf_acc | ALU_OverFlow;
                  iter    <= iter - 1'b1;
                  settle  <= SETTLE_LD;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  last_result <= rsp_data;
                  rsp_valid   <= 1'b0;
                  cmd_ready   <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an adder ALU stub; one instance at
// SETTLE=1 and one at SETTLE=3.
module tb_alu_sequencer;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         cmd_valid = 0, cmd_valid3 = 0, rsp_ready = 0;
   logic [W-1:0] cmd_da = 0, cmd_db = 0;
   logic [2:0]   cmd_ctl = 0;
   logic [3:0]   cmd_shift = 0, cmd_repeat = 0;
   logic         cmd_chain = 0;

   logic         cmd_ready, rsp_valid, rsp_overflow, busy, ovf;
   logic [W-1:0] da, db, dc, rsp_data;
   logic [2:0]   ctl;
   logic [3:0]   shf;

   logic         cmd_ready3, rsp_valid3, rsp_overflow3, busy3, ovf3;
   logic [W-1:0] da3, db3, dc3, rsp_data3;
   logic [2:0]   ctl3;
   logic [3:0]   shf3;

   assign dc   = da + db;
   assign ovf  = (da[W-1] == db[W-1]) && (dc[W-1] != da[W-1]);
   assign dc3  = da3 + db3;
   assign ovf3 = (da3[W-1] == db3[W-1]) && (dc3[W-1] != da3[W-1]);

   alu_sequencer #(.WIDTH(W), .SETTLE(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_da(cmd_da), .cmd_db(cmd_db), .cmd_ctl(cmd_ctl), .cmd_shift(cmd_shift),
      .cmd_chain(cmd_chain), .cmd_repeat(cmd_repeat),
      .ALU_DA(da), .ALU_DB(db), .ALU_CTL(ctl), .ALU_SHIFT(shf),
      .ALU_DC(dc), .ALU_OverFlow(ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_overflow(rsp_overflow), .busy(busy));

   alu_sequencer #(.WIDTH(W), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_da(cmd_da), .cmd_db(cmd_db), .cmd_ctl(cmd_ctl), .cmd_shift(cmd_shift),
      .cmd_chain(cmd_chain), .cmd_repeat(cmd_repeat),
      .ALU_DA(da3), .ALU_DB(db3), .ALU_CTL(ctl3), .ALU_SHIFT(shf3),
      .ALU_DC(dc3), .ALU_OverFlow(ovf3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3),
      .rsp_overflow(rsp_overflow3), .busy(busy3));

   int checks = 0;
   int errs   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command to the SETTLE=1 instance for exactly one accept edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                       input logic ch, input logic [3:0] rep);
      cmd_da = a; cmd_db = b; cmd_ctl = c; cmd_shift = 4'd3; cmd_chain = ch; cmd_repeat = rep;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int exp_lat);
      int n = 0;
      while (!rsp_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
   endtask

   task automatic take();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_drop", rsp_valid, 1'b0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_alu_da", da, 16'h0);
      check("rst_alu_ctl", ctl, 3'h0);
      check("rst_rsp_data", rsp_data, 16'h0);
      rst = 1'b0;
      tick();

      // single op
      send(16'hfff0, 16'h0ff0, 3'b010, 1'b0, 4'd0);
      check("single_ctl", ctl, 3'b010);
      check("single_shift", shf, 4'd3);
      check("single_busy", busy, 1'b1);
      check("single_cmd_ready", cmd_ready, 1'b0);
      wait_rsp("single", 1);
      check("single_data", rsp_data, 16'h0fe0);
      check("single_ovf", rsp_overflow, 1'b0);
      take();

      // iterate 1+1 four times, watching operand A feedback
      tick();
      send(16'h0001, 16'h0001, 3'b000, 1'b0, 4'd3);
      for (int k = 0; k < 4; k++) begin
         check("iter_da", da, 32'(k + 1));
         tick();
      end
      check("iter_rsp_valid", rsp_valid, 1'b1);
      check("iter_data", rsp_data, 16'h0005);
      check("iter_ovf", rsp_overflow, 1'b0);

      // backpressure, with a stray command that must be ignored
      cmd_valid = 1'b1; cmd_da = 16'h1234;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_valid", rsp_valid, 1'b1);
         check("bp_data", rsp_data, 16'h0005);
         check("bp_cmd_ready", cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      take();
      check("bp_idle", busy, 1'b0);

      // chain uses prior result
      send(16'hdead, 16'h000a, 3'b000, 1'b1, 4'd0);
      check("chain_da", da, 16'h0005);
      wait_rsp("chain", 1);
      check("chain_data", rsp_data, 16'h000f);
      take();

      // sticky overflow
      send(16'h7ff0, 16'h0008, 3'b000, 1'b0, 4'd2);
      wait_rsp("ovf", 3);
      check("ovf_data", rsp_data, 16'h8008);
      check("ovf_flag", rsp_overflow, 1'b1);
      take();
      send(16'h0001, 16'h0001, 3'b000, 1'b0, 4'd0);
      wait_rsp("ovf_clr", 1);
      check("ovf_clr_data", rsp_data, 16'h0002);
      check("ovf_clr_flag", rsp_overflow, 1'b0);
      take();

      // SETTLE=3, repeat=1
      cmd_da = 16'h0001; cmd_db = 16'h0001; cmd_chain = 1'b0; cmd_repeat = 4'd1;
      cmd_valid3 = 1'b1;
      tick();
      cmd_valid3 = 1'b0;
      check("s3_da0", da3, 16'h0001);
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c < 6) check("s3_da", da3, (c < 3) ? 32'h1 : 32'h2);
         check("s3_valid", rsp_valid3, (c == 6) ? 32'h1 : 32'h0);
      end
      check("s3_data", rsp_data3, 16'h0003);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("s3_drop", rsp_valid3, 1'b0);

      // reset in the middle of a long command
      send(16'h0001, 16'h0001, 3'b001, 1'b0, 4'd5);
      tick();
      #2 rst = 1'b1;
      #1;
      check("mrst_da", da, 16'h0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_cmd_ready", cmd_ready, 1'b1);
      check("mrst_rsp_data", rsp_data, 16'h0);
      check("mrst_ctl", ctl, 3'h0);
      tick();
      rst = 1'b0;
      begin
         int seen = 0;
         for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid) seen++;
         end
         check("mrst_no_rsp", seen, 0);
      end
      send(16'hdead, 16'h0003, 3'b000, 1'b1, 4'd0);
      check("mrst_chain_da", da, 16'h0);
      wait_rsp("mrst_chain", 1);
      check("mrst_chain_data", rsp_data, 16'h0003);
      take();

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Bus-side initiator for the 16-bit ALU; owns the operand side of the ALU port set (ALU_DA/DB/CTL/SHIFT out, ALU_DC/ALU_OverFlow in).
- Accepts operation commands over a valid/ready handshake, drives registered operands, waits a settle window, then samples the result.
- Optionally iterates an operation, feeding each result back into DA, and returns the final result over a valid/ready response channel.
- Sits between the instruction/control path and the ALU, replacing ad-hoc direct ALU driving.

Parameters:
- WIDTH, 16, datapath width of DA/DB/DC.
- SETTLE, 1, cycles between driving ALU inputs and sampling ALU_DC/ALU_OverFlow (min 1; covers multicycle ALU paths).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_da  in  WIDTH  operand A (ignored when cmd_chain=1).
- cmd_db  in  WIDTH  operand B.
- cmd_ctl  in  3  ALU operation select, passed through opaquely.
- cmd_shift  in  4  ALU shift amount, passed through.
- cmd_chain  in  1  use last returned result as operand A.
- cmd_repeat  in  4  extra iterations; op runs cmd_repeat+1 times.
- ALU_DA, ALU_DB  out  WIDTH  registered ALU operands.
- ALU_CTL  out  3  registered op select.
- ALU_SHIFT  out  4  registered shift amount.
- ALU_DC  in  WIDTH  ALU result.
- ALU_OverFlow  in  1  ALU overflow flag.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  WIDTH  final result.
- rsp_overflow  out  1  OR of ALU_OverFlow over all iterations of the command.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_overflow=0; busy=0; ALU_DA/DB=0; ALU_CTL=0; ALU_SHIFT=0; last_result=0; iteration and settle counters=0.
- States: IDLE, DRIVE, RESP.
- IDLE: cmd_ready=1. Accept when cmd_valid & cmd_ready at a rising edge.
  - At the accept edge: ALU_DA <= cmd_chain ? last_result : cmd_da; ALU_DB/CTL/SHIFT <= command fields; iter <= cmd_repeat; settle <= SETTLE-1; ovf_acc <= 0; go to DRIVE.
- DRIVE: cmd_ready=0; ALU_* outputs are held stable.
  - If settle != 0: decrement settle.
  - Else sample: ovf_acc | ALU_OverFlow is accumulated.
    - If iter == 0: rsp_data <= ALU_DC; rsp_overflow <= accumulated ovf; go to RESP.
    - Else: ALU_DA <= ALU_DC; iter decrements; settle <= SETTLE-1; remain in DRIVE.
- RESP: rsp_valid=1; rsp_data and rsp_overflow are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: last_result <= rsp_data; go to IDLE.
  - rsp_valid drops the cycle after the handshake.
- Latency: rsp_valid rises exactly (cmd_repeat+1)*SETTLE cycles after the accept edge. With SETTLE=1 and repeat=0, rsp_valid is high in the cycle after acceptance.
- No overlap: a new command is accepted only after the response handshake, so at least 1 IDLE cycle separates commands.
- ALU outputs hold their last driven values in IDLE and RESP; they change only at accept or at an iteration feedback edge.
- Arithmetic: no local arithmetic. The result is WIDTH bits taken verbatim from ALU_DC. Overflow is sticky only within one command.
- cmd_chain applies to the first iteration's DA only; later iterations always use feedback.
- cmd_chain on the first command after reset uses last_result=0.
- cmd_repeat=15 gives 16 iterations; the counter does not wrap.
- cmd_valid deasserted while not ready: ignored, no state change.
- rst asserted mid-DRIVE or mid-RESP: immediate return to reset values; the in-flight command is discarded and no response is produced; last_result is cleared.

Test Plan:
- Bench ALU stub: DC=DA+DB (mod 2^16), OverFlow=signed add overflow, SETTLE=1.
- Single op: da=16'hfff0, db=16'h0ff0, ctl=3'b010, repeat=0 -> rsp_valid 1 cycle after accept; rsp_data=16'h0fe0; rsp_overflow=0; ALU_CTL=3'b010.
- Iterate: da=1, db=1, repeat=3 -> ALU_DA steps 1,2,3,4; rsp_valid after 4 cycles; rsp_data=16'h0005; rsp_overflow=0.
- Overflow sticky: da=16'h7ff0, db=16'h0008, repeat=2 -> iterations give 7ff8, 8000 (ovf), 8008; rsp_data=16'h8008; rsp_overflow=1. The next command 1+1 returns rsp_overflow=0.
- Backpressure and chain: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data stable and cmd_ready=0 throughout; after the handshake, cmd_chain=1, da=16'hdead, db=16'h000a -> ALU_DA=prior result; with prior 16'h0005, rsp_data=16'h000f.
- SETTLE=3 with repeat=1 -> rsp_valid exactly 6 cycles after accept; ALU_DA changes only at cycle 3.
- Reset mid-operation: assert rst during DRIVE of a repeat=5 command -> all outputs return to reset values asynchronously; no rsp_valid; a following cmd_chain=1 command uses DA=0.
